// File: rtl/mult_seq_control.sv
// Sequencing controller for the add-shift multiplier: drives clear/load, add, shift and status.
// Run latency: 1 CLR cycle + WIDTH ADD/SHIFT pairs, Done from cycle 2*WIDTH+2 until Execute drops.
// No backpressure: a run always completes once started; Execute is a level request re-armed by dropping it.
module mult_seq_control #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Execute,
    input  logic          ClearA_LoadB,
    input  logic          M,
    input  logic          Signed_Mode,
    output logic          Shift_En,
    output logic          LD,
    output logic          SUB,
    output logic          CLRA,
    output logic          LDB,
    output logic          Busy,
    output logic          Done,
    output logic [CW-1:0] Count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_HOLD  = 3'd4
    } state_e;

    // Count value seen during the final ADD/SHIFT pair; the MSB of a signed
    // multiplier carries negative weight, so its add becomes a subtract.
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_e         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;

    // Next-state and bit-counter update; unused encodings fall back to IDLE.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (Execute) begin
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                count_d = '0;
                state_d = S_ADD;
            end
            S_ADD: begin
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                count_d = count_q + 1'b1;
                state_d = (count_q == LAST_CNT) ? S_HOLD : S_ADD;
            end
            S_HOLD: begin
                if (!Execute) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers; reset abandons any run in progress.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Output decode. LD/SUB follow M in the same ADD cycle and CLRA/LDB follow
    // ClearA_LoadB in IDLE, so these are decoded from state rather than
    // registered. Reset_n gates everything so the datapath sees no strobes while
    // reset is held, even with the switch inputs active.
    always_comb begin
        Shift_En = 1'b0;
        LD       = 1'b0;
        SUB      = 1'b0;
        CLRA     = 1'b0;
        LDB      = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;
        if (Reset_n) begin
            case (state_q)
                S_IDLE: begin
                    // Execute wins over the clear/load request.
                    if (!Execute && ClearA_LoadB) begin
                        CLRA = 1'b1;
                        LDB  = 1'b1;
                    end
                end
                S_CLR: begin
                    CLRA = 1'b1;
                    Busy = 1'b1;
                end
                S_ADD: begin
                    Busy = 1'b1;
                    LD   = M;
                    SUB  = Signed_Mode & M & (count_q == LAST_CNT);
                end
                S_SHIFT: begin
                    Shift_En = 1'b1;
                    Busy     = 1'b1;
                end
                S_HOLD: begin
                    Done = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign Count = count_q;

endmodule

// File: tb/tb_mult_seq_control.sv
// Randomized scoreboard bench for mult_seq_control at WIDTH=8 and WIDTH=16.
// Expected per-cycle outputs come from the run timeline (cycle offsets from the Execute edge).
// A negedge monitor pops one expectation per cycle and compares against the selected DUT.
module tb_mult_seq_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic execute, cl, m, sm;
    logic sel;  // 0: WIDTH=8 instance under test, 1: WIDTH=16 instance

    logic       a_sh, a_ld, a_sub, a_clra, a_ldb, a_busy, a_done;
    logic [3:0] a_cnt;
    logic       b_sh, b_ld, b_sub, b_clra, b_ldb, b_busy, b_done;
    logic [4:0] b_cnt;

    mult_seq_control #(.WIDTH(8)) dut8 (
        .Clk(clk), .Reset_n(rst_n),
        .Execute(execute & ~sel), .ClearA_LoadB(cl & ~sel),
        .M(m), .Signed_Mode(sm),
        .Shift_En(a_sh), .LD(a_ld), .SUB(a_sub), .CLRA(a_clra), .LDB(a_ldb),
        .Busy(a_busy), .Done(a_done), .Count(a_cnt)
    );

    mult_seq_control #(.WIDTH(16)) dut16 (
        .Clk(clk), .Reset_n(rst_n),
        .Execute(execute & sel), .ClearA_LoadB(cl & sel),
        .M(m), .Signed_Mode(sm),
        .Shift_En(b_sh), .LD(b_ld), .SUB(b_sub), .CLRA(b_clra), .LDB(b_ldb),
        .Busy(b_busy), .Done(b_done), .Count(b_cnt)
    );

    typedef struct packed {
        logic       sh;
        logic       ld;
        logic       sub;
        logic       clra;
        logic       ldb;
        logic       busy;
        logic       done;
        logic [4:0] cnt;
    } ctl_t;

    ctl_t act;
    always_comb begin
        if (sel) act = '{b_sh, b_ld, b_sub, b_clra, b_ldb, b_busy, b_done, b_cnt};
        else     act = '{a_sh, a_ld, a_sub, a_clra, a_ldb, a_busy, a_done, {1'b0, a_cnt}};
    end

    ctl_t exp_q[$];
    ctl_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   last_cnt[2];  // Count each DUT shows while idle (0 after reset, WIDTH after a run)

    // Monitor: one expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (act !== mon_e) begin
                failures++;
                $display("FAIL ctl cyc=%0d W=%0d act sh=%b ld=%b sub=%b clra=%b ldb=%b busy=%b done=%b cnt=%0d exp sh=%b ld=%b sub=%b clra=%b ldb=%b busy=%b done=%b cnt=%0d",
                         cyc, sel ? 16 : 8,
                         act.sh, act.ld, act.sub, act.clra, act.ldb, act.busy, act.done, act.cnt,
                         mon_e.sh, mon_e.ld, mon_e.sub, mon_e.clra, mon_e.ldb, mon_e.busy, mon_e.done, mon_e.cnt);
            end
        end
    end

    function automatic ctl_t mk(input logic sh, input logic ld, input logic sub,
                                input logic clra, input logic ldb, input logic busy,
                                input logic done, input int cnt);
        ctl_t r;
        r.sh   = sh;
        r.ld   = ld;
        r.sub  = sub;
        r.clra = clra;
        r.ldb  = ldb;
        r.busy = busy;
        r.done = done;
        r.cnt  = 5'(cnt);
        return r;
    endfunction

    function automatic logic pick(input int v);
        if (v < 0) return 1'($urandom_range(0, 1));
        return 1'(v);
    endfunction

    // Called just after a rising edge with inputs already set for this cycle.
    task automatic cycle_push(input ctl_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            execute = 1'b0;
            cl      = pick(-1);
            m       = pick(-1);
            cycle_push(mk(0, 0, 0, cl, cl, 0, 0, last_cnt[sel]));
        end
    endtask

    // One full multiply run. sm_sel/m_sel: -1 random, else forced value.
    task automatic run(input int w, input int sm_sel, input int m_sel,
                       input bit drop_early, input int extra);
        sm = pick(sm_sel);
        // Execute edge in IDLE, with clear/load also requested: no strobes.
        execute = 1'b1; cl = 1'b1; m = pick(-1);
        cycle_push(mk(0, 0, 0, 0, 0, 0, 0, last_cnt[sel]));
        // Clear cycle; Count still shows the previous value.
        cl = pick(-1); m = pick(-1);
        cycle_push(mk(0, 0, 0, 1, 0, 1, 0, last_cnt[sel]));
        for (int i = 0; i < w; i++) begin
            m  = pick(m_sel);
            cl = pick(-1);
            if (drop_early && i == w / 2) execute = 1'b0;
            cycle_push(mk(0, m, (sm && m && (i == w - 1)), 0, 0, 1, 0, i));
            m = pick(-1);
            cycle_push(mk(1, 0, 0, 0, 0, 1, 0, i));
        end
        // Done holds while Execute stays high; exactly one run per request.
        if (!drop_early) begin
            for (int k = 0; k < extra; k++) begin
                m = pick(-1); cl = pick(-1);
                cycle_push(mk(0, 0, 0, 0, 0, 0, 1, w));
            end
        end
        execute = 1'b0; m = pick(-1); cl = pick(-1);
        cycle_push(mk(0, 0, 0, 0, 0, 0, 1, w));
        last_cnt[sel] = w;
    endtask

    // Run interrupted by reset in the SHIFT cycle with Count=3.
    task automatic run_reset(input int w);
        sm = 1'b1;
        execute = 1'b1; cl = 1'b0; m = pick(-1);
        cycle_push(mk(0, 0, 0, 0, 0, 0, 0, last_cnt[sel]));
        m = pick(-1);
        cycle_push(mk(0, 0, 0, 1, 0, 1, 0, last_cnt[sel]));
        for (int i = 0; i < 4; i++) begin
            m = pick(-1);
            cycle_push(mk(0, m, 0, 0, 0, 1, 0, i));
            if (i < 3) begin
                m = pick(-1);
                cycle_push(mk(1, 0, 0, 0, 0, 1, 0, i));
            end
        end
        // Reset asserted mid-SHIFT with clear/load and M active: everything 0 at once.
        rst_n = 1'b0; cl = 1'b1; m = 1'b1;
        cycle_push(mk(0, 0, 0, 0, 0, 0, 0, 0));
        cycle_push(mk(0, 0, 0, 0, 0, 0, 0, 0));
        last_cnt[0] = 0;
        last_cnt[1] = 0;
        rst_n = 1'b1; execute = 1'b0; cl = 1'b0;
        cycle_push(mk(0, 0, 0, 0, 0, 0, 0, 0));
        // Run abandoned: no Done while idling afterwards.
        idle_cycles(4);
    endtask

    initial begin
        rst_n = 1'b0; execute = 1'b1; cl = 1'b1; m = 1'b1; sm = 1'b1; sel = 1'b0;
        last_cnt[0] = 0;
        last_cnt[1] = 0;
        @(posedge clk);
        #1;
        // Reset held with every input active: all outputs 0.
        cycle_push(mk(0, 0, 0, 0, 0, 0, 0, 0));
        cycle_push(mk(0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        idle_cycles(3);

        // WIDTH=8 directed patterns.
        run(8, 1, 1, 1'b0, 3);  idle_cycles(2);
        run(8, 0, 1, 1'b0, 0);  idle_cycles(1);
        run(8, 0, 0, 1'b0, 1);  idle_cycles(2);
        run(8, 1, 0, 1'b1, 0);  idle_cycles(1);
        // WIDTH=8 random runs.
        for (int r = 0; r < 8; r++) begin
            run(8, -1, -1, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
            idle_cycles($urandom_range(1, 3));
        end
        run_reset(8);

        // WIDTH=16.
        sel = 1'b1;
        idle_cycles(2);
        run(16, 1, 1, 1'b0, 2); idle_cycles(2);
        for (int r = 0; r < 4; r++) begin
            run(16, -1, -1, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
            idle_cycles($urandom_range(1, 3));
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
